// File: rtl/nic_pkt_serializer.sv
// Packet-to-flit serializer between the NIC message buffer and the router
// injection port, with per-vnet credit-based flow control.

`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 5
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef FLIT_TYPE_BITS
`define FLIT_TYPE_BITS 15:14
`endif
`ifndef HEAD_FLIT
`define HEAD_FLIT 2'b00
`endif
`ifndef BODY_FLIT
`define BODY_FLIT 2'b01
`endif
`ifndef TAIL_FLIT
`define TAIL_FLIT 2'b10
`endif
`ifndef HEAD_TAIL_FLIT
`define HEAD_TAIL_FLIT 2'b11
`endif

module nic_pkt_serializer #(
  parameter int N_BITS_VNET_ID  = 2,
  parameter int N_CREDITS       = 4,
  parameter int N_BITS_CREDIT   = 3,
  parameter int N_BITS_FLIT_IDX = 3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [`MAX_PACKET_LENGHT*`FLIT_WIDTH-1:0]    pkt_i,
  input  logic [N_BITS_VNET_ID-1:0]                    vnet_id_i,
  input  logic                                         is_valid_i,
  output logic                                         clear_buffer_o,
  output logic [`FLIT_WIDTH-1:0]                       flit_o,
  output logic                                         flit_valid_o,
  output logic [N_BITS_VNET_ID-1:0]                    flit_vnet_id_o,
  input  logic [(2**N_BITS_VNET_ID)-1:0]               credit_i,
  output logic                                         busy_o
);

  localparam int N_VNET = 2**N_BITS_VNET_ID;
  localparam int FW     = `FLIT_WIDTH;
  localparam int MAXLEN = `MAX_PACKET_LENGHT;
  localparam int PKT_W  = MAXLEN*FW;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                     state, next_state;
  logic [PKT_W-1:0]           pkt_q;
  logic [N_BITS_VNET_ID-1:0]  vnet_q;
  logic [N_BITS_FLIT_IDX-1:0] idx_q;
  logic [N_BITS_CREDIT-1:0]   credit_cnt [N_VNET];

  logic [FW-1:0]              cur_flit;
  logic                       transfer;
  logic                       last_flit;
  logic                       accept;

  // Mux-based flit select keeps indices past the packet end out of range.
  always_comb begin
    cur_flit = '0;
    for (int k = 0; k < MAXLEN; k++) begin
      if (idx_q == N_BITS_FLIT_IDX'(k)) begin
        cur_flit = pkt_q[k*FW +: FW];
      end
    end
  end

  assign transfer  = (state == SEND) && (credit_cnt[vnet_q] != '0);
  assign last_flit = (cur_flit[`FLIT_TYPE_BITS] == `TAIL_FLIT) ||
                     (cur_flit[`FLIT_TYPE_BITS] == `HEAD_TAIL_FLIT) ||
                     (idx_q == N_BITS_FLIT_IDX'(MAXLEN-1));
  assign accept    = (state == IDLE) && is_valid_i;

  always_comb begin
    next_state     = state;
    clear_buffer_o = 1'b0;
    case (state)
      IDLE: begin
        clear_buffer_o = is_valid_i;
        if (is_valid_i) begin
          next_state = SEND;
        end
      end
      SEND: begin
        if (transfer && last_flit) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_q  <= '0;
      vnet_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      pkt_q  <= pkt_i;
      vnet_q <= vnet_id_i;
      idx_q  <= '0;
    end else if (transfer) begin
      idx_q  <= last_flit ? '0 : idx_q + N_BITS_FLIT_IDX'(1);
    end
  end

  // A returned credit and a transfer on the same vnet cancel out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < N_VNET; v++) begin
        credit_cnt[v] <= N_BITS_CREDIT'(N_CREDITS);
      end
    end else begin
      for (int v = 0; v < N_VNET; v++) begin
        if (transfer && (vnet_q == N_BITS_VNET_ID'(v)) && !credit_i[v]) begin
          credit_cnt[v] <= credit_cnt[v] - N_BITS_CREDIT'(1);
        end else if (credit_i[v] && !(transfer && (vnet_q == N_BITS_VNET_ID'(v))) &&
                     (credit_cnt[v] != N_BITS_CREDIT'(N_CREDITS))) begin
          credit_cnt[v] <= credit_cnt[v] + N_BITS_CREDIT'(1);
        end
      end
    end
  end

  assign flit_o         = cur_flit;
  assign flit_valid_o   = transfer;
  assign flit_vnet_id_o = vnet_q;
  assign busy_o         = (state == SEND);

endmodule

// File: tb/tb_nic_pkt_serializer.sv
// Directed bench for nic_pkt_serializer: one linear sequence of cycles,
// each with hand-derived expected outputs checked by immediate assertions.

`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 5
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef HEAD_FLIT
`define HEAD_FLIT 2'b00
`endif
`ifndef BODY_FLIT
`define BODY_FLIT 2'b01
`endif
`ifndef TAIL_FLIT
`define TAIL_FLIT 2'b10
`endif
`ifndef HEAD_TAIL_FLIT
`define HEAD_TAIL_FLIT 2'b11
`endif

module tb_nic_pkt_serializer;

  localparam int FW    = `FLIT_WIDTH;
  localparam int PKT_W = `MAX_PACKET_LENGHT*`FLIT_WIDTH;

  logic             clk;
  logic             rst;
  logic [PKT_W-1:0] pkt_i;
  logic [1:0]       vnet_id_i;
  logic             is_valid_i;
  logic             clear_buffer_o;
  logic [FW-1:0]    flit_o;
  logic             flit_valid_o;
  logic [1:0]       flit_vnet_id_o;
  logic [3:0]       credit_i;
  logic             busy_o;

  int total = 0;
  int bad   = 0;

  logic [PKT_W-1:0] p1, p2, p3, p4, p5, p6, p7;

  nic_pkt_serializer #(
    .N_BITS_VNET_ID (2),
    .N_CREDITS      (4),
    .N_BITS_CREDIT  (3),
    .N_BITS_FLIT_IDX(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_i         (pkt_i),
    .vnet_id_i     (vnet_id_i),
    .is_valid_i    (is_valid_i),
    .clear_buffer_o(clear_buffer_o),
    .flit_o        (flit_o),
    .flit_valid_o  (flit_valid_o),
    .flit_vnet_id_o(flit_vnet_id_o),
    .credit_i      (credit_i),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mkFlit(input logic [1:0] t, input logic [13:0] payload);
    return {t, payload};
  endfunction

  function automatic logic [FW-1:0] getFlit(input logic [PKT_W-1:0] p, input int k);
    return p[k*FW +: FW];
  endfunction

  // Starts a new cycle: drive inputs 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [1:0] vn,
                               input logic [PKT_W-1:0] p, input logic [3:0] cr);
    @(posedge clk);
    #1;
    rst        = r;
    is_valid_i = v;
    vnet_id_i  = vn;
    pkt_i      = p;
    credit_i   = cr;
  endtask

  task automatic checkOutput(input string tag, input logic cb, input logic fv,
                             input logic bsy, input logic [FW-1:0] fl, input logic [1:0] fvn);
    #1;
    total++;
    assert (clear_buffer_o === cb) else begin
      bad++;
      $error("FAIL %s.clear_buffer observed=%0b expected=%0b", tag, clear_buffer_o, cb);
    end
    total++;
    assert (flit_valid_o === fv) else begin
      bad++;
      $error("FAIL %s.flit_valid observed=%0b expected=%0b", tag, flit_valid_o, fv);
    end
    total++;
    assert (busy_o === bsy) else begin
      bad++;
      $error("FAIL %s.busy observed=%0b expected=%0b", tag, busy_o, bsy);
    end
    total++;
    assert (flit_o === fl) else begin
      bad++;
      $error("FAIL %s.flit observed=%h expected=%h", tag, flit_o, fl);
    end
    total++;
    assert (flit_vnet_id_o === fvn) else begin
      bad++;
      $error("FAIL %s.flit_vnet observed=%0d expected=%0d", tag, flit_vnet_id_o, fvn);
    end
  endtask

  initial begin
    rst        = 1'b0;
    is_valid_i = 1'b0;
    vnet_id_i  = '0;
    pkt_i      = '0;
    credit_i   = '0;

    p1 = {48'h0, mkFlit(`HEAD_TAIL_FLIT, 14'h0AB)};
    p2 = {16'h0, mkFlit(`TAIL_FLIT, 14'h0204), mkFlit(`BODY_FLIT, 14'h0203),
          mkFlit(`BODY_FLIT, 14'h0202), mkFlit(`HEAD_FLIT, 14'h0201)};
    p3 = {48'h0, mkFlit(`TAIL_FLIT, 14'h0302), mkFlit(`HEAD_FLIT, 14'h0301)};
    p4 = {48'h0, mkFlit(`TAIL_FLIT, 14'h0402), mkFlit(`HEAD_FLIT, 14'h0401)};
    p5 = {mkFlit(`BODY_FLIT, 14'h0505), mkFlit(`BODY_FLIT, 14'h0504),
          mkFlit(`BODY_FLIT, 14'h0503), mkFlit(`BODY_FLIT, 14'h0502),
          mkFlit(`HEAD_FLIT, 14'h0501)};
    p6 = {16'h0, mkFlit(`TAIL_FLIT, 14'h0604), mkFlit(`BODY_FLIT, 14'h0603),
          mkFlit(`BODY_FLIT, 14'h0602), mkFlit(`HEAD_FLIT, 14'h0601)};
    p7 = {16'h0, mkFlit(`TAIL_FLIT, 14'h0704), mkFlit(`BODY_FLIT, 14'h0703),
          mkFlit(`BODY_FLIT, 14'h0702), mkFlit(`HEAD_FLIT, 14'h0701)};

    $display("[TB] starting nic_pkt_serializer directed sequence");

    // Reset, then idle outputs.
    applyStimulus(1'b0, 1'b0, 2'd0, '0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 2'd0, '0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("reset", 1'b0, 1'b0, 1'b0, '0, 2'd0);

    // Single HEAD_TAIL flit on vnet 2.
    applyStimulus(1'b1, 1'b1, 2'd2, p1, 4'b0000);
    checkOutput("ht_accept", 1'b1, 1'b0, 1'b0, '0, 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("ht_flit", 1'b0, 1'b1, 1'b1, getFlit(p1, 0), 2'd2);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("ht_idle", 1'b0, 1'b0, 1'b0, getFlit(p1, 0), 2'd2);

    // 4-flit packet on vnet 0 exhausts its credits; p3 waits at the input.
    applyStimulus(1'b1, 1'b1, 2'd0, p2, 4'b0000);
    checkOutput("p2_accept", 1'b1, 1'b0, 1'b0, getFlit(p1, 0), 2'd2);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, p3, 4'b0000);
      checkOutput($sformatf("p2_flit%0d", k), 1'b0, 1'b1, 1'b1, getFlit(p2, k), 2'd0);
    end
    applyStimulus(1'b1, 1'b1, 2'd0, p3, 4'b0000);
    checkOutput("p3_accept", 1'b1, 1'b0, 1'b0, getFlit(p2, 0), 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("p3_nocredit", 1'b0, 1'b0, 1'b1, getFlit(p3, 0), 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0001);
    checkOutput("p3_credit_cycle", 1'b0, 1'b0, 1'b1, getFlit(p3, 0), 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("p3_head", 1'b0, 1'b1, 1'b1, getFlit(p3, 0), 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0001);
    checkOutput("p3_stall", 1'b0, 1'b0, 1'b1, getFlit(p3, 1), 2'd0);
    // Transfer plus credit in the same cycle leaves vnet 0 at one credit.
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0001);
    checkOutput("p3_tail_with_credit", 1'b0, 1'b1, 1'b1, getFlit(p3, 1), 2'd0);

    // p4 on vnet 0: exactly one credit means head goes, tail stalls.
    applyStimulus(1'b1, 1'b1, 2'd0, p4, 4'b0000);
    checkOutput("p4_accept", 1'b1, 1'b0, 1'b0, getFlit(p3, 0), 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("p4_head", 1'b0, 1'b1, 1'b1, getFlit(p4, 0), 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0001);
    checkOutput("p4_stall", 1'b0, 1'b0, 1'b1, getFlit(p4, 1), 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("p4_tail", 1'b0, 1'b1, 1'b1, getFlit(p4, 1), 2'd0);

    // Credits on full vnet 1 saturate; tail-less 5-flit packet stalls at flit 4.
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0010);
    checkOutput("sat_credit0", 1'b0, 1'b0, 1'b0, getFlit(p4, 0), 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0010);
    checkOutput("sat_credit1", 1'b0, 1'b0, 1'b0, getFlit(p4, 0), 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd1, p5, 4'b0000);
    checkOutput("p5_accept", 1'b1, 1'b0, 1'b0, getFlit(p4, 0), 2'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
      checkOutput($sformatf("p5_flit%0d", k), 1'b0, 1'b1, 1'b1, getFlit(p5, k), 2'd1);
    end
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0010);
    checkOutput("p5_stall", 1'b0, 1'b0, 1'b1, getFlit(p5, 4), 2'd1);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("p5_flit4", 1'b0, 1'b1, 1'b1, getFlit(p5, 4), 2'd1);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("p5_maxlen_idle", 1'b0, 1'b0, 1'b0, getFlit(p5, 0), 2'd1);

    // vnet 2 has three credits left after the HEAD_TAIL packet.
    applyStimulus(1'b1, 1'b1, 2'd2, p6, 4'b0000);
    checkOutput("p6_accept", 1'b1, 1'b0, 1'b0, getFlit(p5, 0), 2'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
      checkOutput($sformatf("p6_flit%0d", k), 1'b0, 1'b1, 1'b1, getFlit(p6, k), 2'd2);
    end
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("p6_stall0", 1'b0, 1'b0, 1'b1, getFlit(p6, 3), 2'd2);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0100);
    checkOutput("p6_stall1", 1'b0, 1'b0, 1'b1, getFlit(p6, 3), 2'd2);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("p6_flit3", 1'b0, 1'b1, 1'b1, getFlit(p6, 3), 2'd2);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("p6_idle", 1'b0, 1'b0, 1'b0, getFlit(p6, 0), 2'd2);

    // Reset while flit 2 of p7 is pending; is_valid_i during SEND is ignored.
    applyStimulus(1'b1, 1'b1, 2'd3, p7, 4'b0000);
    checkOutput("p7_accept", 1'b1, 1'b0, 1'b0, getFlit(p6, 0), 2'd2);
    applyStimulus(1'b1, 1'b1, 2'd0, p2, 4'b0000);
    checkOutput("p7_flit0", 1'b0, 1'b1, 1'b1, getFlit(p7, 0), 2'd3);
    applyStimulus(1'b1, 1'b1, 2'd0, p2, 4'b0000);
    checkOutput("p7_flit1", 1'b0, 1'b1, 1'b1, getFlit(p7, 1), 2'd3);
    applyStimulus(1'b0, 1'b1, 2'd0, p2, 4'b0000);
    checkOutput("p7_flit2_rst", 1'b0, 1'b1, 1'b1, getFlit(p7, 2), 2'd3);
    applyStimulus(1'b1, 1'b1, 2'd0, p2, 4'b0000);
    checkOutput("post_rst", 1'b1, 1'b0, 1'b0, '0, 2'd0);

    // vnet 0 was empty before the reset; four back-to-back flits prove restore.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
      checkOutput($sformatf("restore_flit%0d", k), 1'b0, 1'b1, 1'b1, getFlit(p2, k), 2'd0);
    end
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("restore_idle", 1'b0, 1'b0, 1'b0, getFlit(p2, 0), 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
